// File: rtl/rr_mux_arbiter.sv
// Four-requester round-robin arbiter driving a shared 4:1 mux into one
// registered output word with a valid/ready handshake and optional burst lock.
module rr_mux_arbiter #(
  parameter int WIDTH     = 2,
  parameter int MAX_BURST = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       req,
  input  logic [3:0]       lock,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  input  logic [WIDTH-1:0] d,
  output logic [3:0]       ack,
  output logic [1:0]       s,
  output logic [WIDTH-1:0] y,
  output logic             y_valid,
  input  logic             y_ready
);

  localparam logic [0:0] IDLE      = 1'b0;
  localparam logic [0:0] FULL      = 1'b1;
  localparam logic [3:0] BURST_LIM = 4'(MAX_BURST - 1);

  logic [0:0]       state;
  logic [1:0]       last;
  logic [3:0]       burst_cnt;
  logic             lock_hit_p0;
  logic             cap_p0;
  logic [1:0]       winner_p0;
  logic [WIDTH-1:0] word_p0;

  // Saturating so a long single-requester run can never wrap back into the lock window.
  function automatic logic [3:0] sat_inc(input logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction

  // First asserted request strictly after l, wrapping; l itself is checked last.
  function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] l);
    logic [1:0] idx;
    logic [1:0] pick;
    logic       found;
    pick  = l;
    found = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      idx = l + 2'(k);
      if (!found && r[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  assign y_valid = (state == FULL);

  // Stage p0: combinational winner selection and mux in the capture cycle
  assign lock_hit_p0 = lock[last] & req[last] & (burst_cnt < BURST_LIM);
  assign winner_p0   = lock_hit_p0 ? last : rr_pick(req, last);
  assign cap_p0      = (|req) & ((state == IDLE) | y_ready);

  always_comb begin
    word_p0 = a;
    case (winner_p0)
      2'd0:    word_p0 = a;
      2'd1:    word_p0 = b;
      2'd2:    word_p0 = c;
      default: word_p0 = d;
    endcase
  end

  // Stage p1: registered output word, handshake state and grant history
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      last      <= 2'd3;
      burst_cnt <= 4'd0;
      ack       <= 4'd0;
      y         <= '0;
      s         <= 2'd0;
    end else begin
      ack <= cap_p0 ? (4'b0001 << winner_p0) : 4'd0;
      if (cap_p0) begin
        y         <= word_p0;
        s         <= winner_p0;
        last      <= winner_p0;
        state     <= FULL;
        burst_cnt <= ((winner_p0 == last) && lock[winner_p0]) ? sat_inc(burst_cnt) : 4'd0;
      end else if ((state == FULL) && y_ready) begin
        state <= IDLE;
      end
    end
  end

endmodule
